// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the mux_4x1 select arbiter: select width, input
// count, FSM state encoding and a one-hot helper.
package mux_sel_arbiter_pkg;

  localparam int MUX_SEL_W = 2;
  localparam int MUX_N     = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // One-hot decode of a mux select index.
  function automatic logic [MUX_N-1:0] sel_onehot(input logic [MUX_SEL_W-1:0] idx);
    return MUX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Combinational rotating-priority encoder. Scans last+1, last+2, last+3,
// last (mod 4) and returns the first requester found. mask_en removes
// mask_idx from the scan so a releasing or timed-out holder is skipped.
module mux_rr_pick
  import mux_sel_arbiter_pkg::*;
(
  input  logic [MUX_N-1:0]     req,
  input  logic [MUX_SEL_W-1:0] last,
  input  logic [MUX_SEL_W-1:0] mask_idx,
  input  logic                 mask_en,
  output logic                 found,
  output logic [MUX_SEL_W-1:0] idx
);

  logic [MUX_SEL_W-1:0] cand;

  // Walk the four candidates in rotating order, keeping the first eligible one.
  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = last;
    for (int k = 1; k <= MUX_N; k++) begin
      cand = last + MUX_SEL_W'(k);
      if (!found && req[cand] && !(mask_en && (cand == mask_idx))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a downstream mux_4x1.
// Registered sel/grant/valid; a grant is held while its requester keeps req
// high, and on release the next requester is granted on the same edge.
// Optional feature macro: MUX_ARB_TIMEOUT_EN (forces rotation after HOLD_MAX
// consecutive cycles when another requester is waiting).
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int HOLD_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [MUX_N-1:0]     req,
  output logic [MUX_SEL_W-1:0] sel,
  output logic [MUX_N-1:0]     grant,
  output logic                 valid,
  output arb_state_e           dbg_state
);

  arb_state_e           state;
  logic [MUX_SEL_W-1:0] last;
  logic                 pick_found;
  logic [MUX_SEL_W-1:0] pick_idx;
  logic                 holder_keep;

  // In GRANT the current holder is excluded so a re-pick always moves on;
  // in IDLE the scan is unmasked and starts after the last winner.
  mux_rr_pick u_pick (
    .req      (req),
    .last     (last),
    .mask_idx (sel),
    .mask_en  (state == ARB_GRANT),
    .found    (pick_found),
    .idx      (pick_idx)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  logic [HOLD_W-1:0] hold_cnt;

  // Holder keeps the grant unless it has used its full slice and someone waits.
  always_comb begin
    holder_keep = req[sel] && !((hold_cnt == HOLD_LAST) && pick_found);
  end
`else
  // Holder keeps the grant for as long as its request stays high.
  always_comb begin
    holder_keep = req[sel];
  end
`endif

  // Arbiter FSM with registered outputs; en=0 freezes every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      sel      <= '0;
      grant    <= '0;
      valid    <= 1'b0;
      last     <= '1;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else if (en) begin
      if (state == ARB_IDLE) begin
        if (pick_found) begin
          state    <= ARB_GRANT;
          sel      <= pick_idx;
          grant    <= sel_onehot(pick_idx);
          valid    <= 1'b1;
          last     <= pick_idx;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_cnt <= '0;
`endif
        end
      end else begin
        if (holder_keep) begin
`ifdef MUX_ARB_TIMEOUT_EN
          if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
`endif
        end else if (pick_found) begin
          sel      <= pick_idx;
          grant    <= sel_onehot(pick_idx);
          last     <= pick_idx;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_cnt <= '0;
`endif
        end else begin
          state <= ARB_IDLE;
          grant <= '0;
          valid <= 1'b0;
        end
      end
    end
  end

  assign dbg_state = state;

endmodule
